// File: rtl/img_in_loader_if.sv
// Pixel stream (valid/ready) and image-memory write port of the input loader.
// The master modport is the upstream/memory side; the slave modport is the loader.
interface img_in_loader_if #(
  parameter int ADDR_W = 19
);
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_last;
  logic              s_ready;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;
  logic              mem_we;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, mem_waddr, mem_wdata, mem_we
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, mem_waddr, mem_wdata, mem_we
  );
endinterface

// File: rtl/img_in_loader.sv
// Loads one raster-order 8-bit pixel stream into mem_in, checking frame size and
// framing and keeping a 16-bit running checksum. All outputs are registered.
module img_in_loader #(
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       cfg_w,
  input  logic [15:0]       cfg_h,
  img_in_loader_if.slave    bus,
  output logic              busy,
  output logic              done,
  output logic              err_size,
  output logic              err_frame,
  output logic [ADDR_W:0]   pix_count,
  output logic [15:0]       checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_e;

  localparam logic [31:0] FRAME_MAX = 32'd1 << ADDR_W;

  state_e            state_q;
  logic [31:0]       total_q;
  logic [ADDR_W:0]   pix_count_q;
  logic [15:0]       checksum_q;
  logic              busy_q, done_q, s_ready_q, err_size_q, err_frame_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_waddr_q;
  logic [7:0]        mem_wdata_q;

  logic [31:0]       total_d;
  logic              cfg_bad;
  logic              accept;
  logic              last_pix;

  always_comb begin
    total_d  = 32'(cfg_w) * 32'(cfg_h);
    cfg_bad  = (cfg_w == 16'd0) || (cfg_h == 16'd0) || (total_d > FRAME_MAX);
    accept   = bus.s_valid & s_ready_q;
    last_pix = (32'(pix_count_q) == total_q - 32'd1);
  end

  // Reset is synchronous and active-high despite the port name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= IDLE;
      total_q     <= '0;
      pix_count_q <= '0;
      checksum_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      s_ready_q   <= 1'b0;
      err_size_q  <= 1'b0;
      err_frame_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      // NOTE: default assignment keeps mem_we a single-cycle strobe per accepted beat.
      mem_we_q <= 1'b0;
      case (state_q)
        LOAD: begin
          if (accept) begin
            mem_we_q    <= 1'b1;
            mem_waddr_q <= pix_count_q[ADDR_W-1:0];
            mem_wdata_q <= bus.s_data;
            pix_count_q <= pix_count_q + 1'b1;
            checksum_q  <= checksum_q + {8'd0, bus.s_data};
            if (last_pix || bus.s_last) begin
              // Framing is good only when s_last coincides with the final pixel.
              err_frame_q <= (last_pix != bus.s_last);
              state_q     <= DONE;
              busy_q      <= 1'b0;
              s_ready_q   <= 1'b0;
              done_q      <= 1'b1;
            end
          end
        end
        default: begin
          if (start) begin
            total_q     <= total_d;
            pix_count_q <= '0;
            checksum_q  <= '0;
            err_frame_q <= 1'b0;
            if (cfg_bad) begin
              state_q    <= ERR;
              err_size_q <= 1'b1;
              done_q     <= 1'b1;
              busy_q     <= 1'b0;
              s_ready_q  <= 1'b0;
            end else begin
              state_q    <= LOAD;
              err_size_q <= 1'b0;
              done_q     <= 1'b0;
              busy_q     <= 1'b1;
              s_ready_q  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_waddr = mem_waddr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_size      = err_size_q;
  assign err_frame     = err_frame_q;
  assign pix_count     = pix_count_q;
  assign checksum      = checksum_q;

endmodule
